// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: control-field bit positions and MEM-stage state encoding
package mem_access_stage_pkg;
   localparam int M_MEMREAD   = 1;
   localparam int M_MEMWRITE  = 0;
   localparam int WB_REGWRITE = 1;
   typedef enum logic {ST_IDLE, ST_WAIT} state_t;
endpackage

// File: rtl/mem_access_stage_timeout_ctr.sv
// mem_timeout_ctr: wait-cycle counter that flags expiry at TIMEOUT-1
module mem_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0] cnt;
   assign expire = cnt == CW'(TIMEOUT - 1);
   // count unanswered wait cycles, saturating at the expiry value
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en && !expire) cnt <= cnt + CW'(1);
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage driving a req/ack data memory and loading MEM/WB
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int SIZE      = 32,
   parameter int ADDR_SIZE = 5,
   parameter int S_WB      = 2,
   parameter int S_M       = 3,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [S_WB-1:0]      WB_in,
   input  logic [S_M-1:0]       M_in,
   input  logic [SIZE-1:0]      alu_result,
   input  logic [SIZE-1:0]      store_data,
   input  logic [ADDR_SIZE-1:0] AWriteReg_in,
   output logic                 stall,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [SIZE-1:0]      dmem_addr,
   output logic [SIZE-1:0]      dmem_wdata,
   input  logic                 dmem_ack,
   input  logic [SIZE-1:0]      dmem_rdata,
   output logic [S_WB-1:0]      WB_out,
   output logic [SIZE-1:0]      read_data_out,
   output logic [SIZE-1:0]      alu_out,
   output logic [ADDR_SIZE-1:0] AWriteReg_out,
   output logic                 valid_out,
   output logic                 timeout_err
);
   state_t                 state, state_nx;
   logic                   memop, done, expire;
   logic [S_WB-1:0]        wb_q;
   logic [ADDR_SIZE-1:0]   rd_q;
   logic                   unused_branch;
   assign unused_branch = M_in[S_M-1];
   mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .clr    (state == ST_IDLE),
      .en     (state == ST_WAIT && !dmem_ack),
      .expire (expire)
   );
   // next state and EX/MEM hold; a timeout completes like an ack
   always_comb begin
      memop    = M_in[M_MEMREAD] | M_in[M_MEMWRITE];
      done     = state == ST_WAIT && (dmem_ack || expire);
      state_nx = state == ST_IDLE ? (memop ? ST_WAIT : ST_IDLE) : (done ? ST_IDLE : ST_WAIT);
      stall    = state == ST_IDLE ? memop : !done;
   end
   // state register
   always_ff @(posedge clk)
      state <= rst ? ST_IDLE : state_nx;
   // memory request and MEM/WB register
   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         wb_q          <= '0;
         rd_q          <= '0;
         WB_out        <= '0;
         read_data_out <= '0;
         alu_out       <= '0;
         AWriteReg_out <= '0;
         valid_out     <= 1'b0;
         timeout_err   <= 1'b0;
      end else if (state == ST_IDLE && memop) begin
         dmem_req   <= 1'b1;
         dmem_we    <= M_in[M_MEMWRITE];
         dmem_addr  <= alu_result;
         dmem_wdata <= store_data;
         wb_q       <= WB_in;
         rd_q       <= AWriteReg_in;
         WB_out     <= '0;
         valid_out  <= 1'b0;
      end else if (state == ST_IDLE) begin
         WB_out        <= WB_in;
         read_data_out <= '0;
         alu_out       <= alu_result;
         AWriteReg_out <= AWriteReg_in;
         valid_out     <= 1'b1;
      end else if (done) begin
         dmem_req      <= 1'b0;
         WB_out        <= dmem_ack ? wb_q : wb_q & ~(S_WB'(1) << WB_REGWRITE);
         read_data_out <= (dmem_we || !dmem_ack) ? '0 : dmem_rdata;
         alu_out       <= dmem_addr;
         AWriteReg_out <= rd_q;
         valid_out     <= 1'b1;
         timeout_err   <= timeout_err | !dmem_ack;
      end else begin
         WB_out    <= '0;
         valid_out <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for the MEM stage with a scripted memory responder
module tb_mem_access_stage;
   typedef struct {
      logic [1:0]  wb;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  rd;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  WB_in = '0;
   logic [2:0]  M_in = '0;
   logic [31:0] alu_result = '0, store_data = '0;
   logic [4:0]  AWriteReg_in = '0;
   logic        stall, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [1:0]  WB_out;
   logic [31:0] read_data_out, alu_out;
   logic [4:0]  AWriteReg_out;
   logic        valid_out, timeout_err;
   int          n_checks = 0, n_fail = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   int          ack_delay = 0;
   bit          ack_never = 0, force_ack = 0, gap_chk = 0, gap_seen = 0;
   logic [31:0] mem_rdata = '0, exp_addr = '0, exp_wdata = '0;
   logic        exp_we = 1'b0;
   int          sc;
   mem_access_stage #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .WB_in(WB_in), .M_in(M_in), .alu_result(alu_result),
      .store_data(store_data), .AWriteReg_in(AWriteReg_in), .stall(stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .WB_out(WB_out),
      .read_data_out(read_data_out), .alu_out(alu_out), .AWriteReg_out(AWriteReg_out),
      .valid_out(valid_out), .timeout_err(timeout_err)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic issue(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rdat,
                        output int stalls);
      exp_t e;
      bit   s, ok;
      e.wb    = ack_never ? (wb & 2'b01) : wb;
      e.rdata = ((m[1] | m[0]) && !m[0] && !ack_never) ? rdat : 32'h0;
      e.alu   = alu;
      e.rd    = rd;
      sb.push_back(e);
      exp_addr  = alu;
      exp_we    = m[0];
      exp_wdata = sd;
      mem_rdata = rdat;
      @(negedge clk);
      WB_in = wb; M_in = m; alu_result = alu; store_data = sd; AWriteReg_in = rd;
      stalls = 0;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         #4 s = stall;
         @(posedge clk);
         if (!s) ok = 1;
         else begin
            stalls++;
            @(negedge clk);
         end
      end
      if (!ok) check("issue_timeout", 0, 1);
   endtask
   initial begin
      int cyc = 0, rc = 0, fall_cyc = 0;
      logic prev_req = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (dmem_req) begin
            check("req_addr", dmem_addr, exp_addr);
            check("req_we", dmem_we, exp_we);
            check("req_wdata", dmem_wdata, exp_wdata);
            if (!prev_req && gap_chk) begin
               check("req_gap", cyc - fall_cyc, 1);
               gap_seen = 1;
            end
            dmem_ack   = !ack_never && rc == ack_delay;
            dmem_rdata = mem_rdata;
            rc++;
         end else begin
            if (prev_req) fall_cyc = cyc;
            dmem_ack = force_ack;
            rc = 0;
         end
         prev_req = dmem_req;
      end
   end
   initial forever begin
      @(posedge clk);
      #1;
      if (valid_out) begin
         if (sb.size() == 0) check("unexpected_valid", 1, 0);
         else begin
            mon_e = sb.pop_front();
            check("mw_wb", WB_out, mon_e.wb);
            check("mw_rdata", read_data_out, mon_e.rdata);
            check("mw_alu", alu_out, mon_e.alu);
            check("mw_rd", AWriteReg_out, mon_e.rd);
         end
      end
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", valid_out, 0);
      check("rst_req", dmem_req, 0);
      check("rst_wb", WB_out, 0);
      check("rst_terr", timeout_err, 0);
      check("rst_stall", stall, 0);
      sb.push_back('{2'b00, 32'h0, 32'h0, 5'd0});
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      issue(2'b10, 3'b000, 32'h1234, 32'h0, 5'd5, 32'h0, sc);
      #1;
      check("rtype_stalls", sc, 0);
      check("rtype_valid", valid_out, 1);
      check("rtype_wb", WB_out, 2'b10);
      check("rtype_alu", alu_out, 32'h1234);
      check("rtype_stall", stall, 0);
      ack_delay = 3;
      issue(2'b11, 3'b010, 32'h40, 32'h0, 5'd7, 32'hDEADBEEF, sc);
      #1;
      check("load_stalls", sc, 4);
      check("load_rdata", read_data_out, 32'hDEADBEEF);
      check("load_valid", valid_out, 1);
      ack_delay = 0;
      issue(2'b00, 3'b001, 32'h80, 32'hA5A5A5A5, 5'd0, 32'hFFFFFFFF, sc);
      #1;
      check("store_stalls", sc, 1);
      check("store_rdata", read_data_out, 32'h0);
      ack_never = 1;
      issue(2'b11, 3'b010, 32'h44, 32'h0, 5'd9, 32'h1111, sc);
      #1;
      check("to_err", timeout_err, 1);
      check("to_wb", WB_out, 2'b01);
      check("to_req", dmem_req, 0);
      ack_never = 0;
      issue(2'b10, 3'b000, 32'h7, 32'h0, 5'd1, 32'h0, sc);
      #1;
      check("to_sticky", timeout_err, 1);
      issue(2'b00, 3'b011, 32'h90, 32'h55AA, 5'd0, 32'h2222, sc);
      #1;
      check("wprio_rdata", read_data_out, 32'h0);
      issue(2'b11, 3'b010, 32'hA0, 32'h0, 5'd3, 32'hCAFE0001, sc);
      gap_chk = 1;
      issue(2'b11, 3'b010, 32'hA4, 32'h0, 5'd4, 32'hCAFE0002, sc);
      gap_chk = 0;
      check("gap_seen", gap_seen, 1);
      exp_addr = 32'h200; exp_we = 1'b0; exp_wdata = 32'h0; ack_delay = 3; mem_rdata = 32'hBAD;
      @(negedge clk);
      WB_in = 2'b11; M_in = 3'b010; alu_result = 32'h200; store_data = 32'h0; AWriteReg_in = 5'd6;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      WB_in = '0; M_in = '0; alu_result = '0; AWriteReg_in = '0;
      @(posedge clk);
      #1;
      check("mrst_req", dmem_req, 0);
      check("mrst_we", dmem_we, 0);
      check("mrst_addr", dmem_addr, 0);
      check("mrst_wdata", dmem_wdata, 0);
      check("mrst_wb", WB_out, 0);
      check("mrst_rdata", read_data_out, 0);
      check("mrst_alu", alu_out, 0);
      check("mrst_rd", AWriteReg_out, 0);
      check("mrst_valid", valid_out, 0);
      check("mrst_terr", timeout_err, 0);
      check("mrst_stall", stall, 0);
      @(negedge clk);
      force_ack = 1;
      @(posedge clk);
      #1;
      check("mrst_req2", dmem_req, 0);
      check("mrst_valid2", valid_out, 0);
      sb.push_back('{2'b00, 32'h0, 32'h0, 5'd0});
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("ackidle_req", dmem_req, 0);
      check("ackidle_stall", stall, 0);
      force_ack = 0;
      issue(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0, sc);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #2;
      check("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
